// File: rtl/jalr_dest_tracker.sv
// rtl/jalr_dest_tracker.sv - shadow EX/MEM/WB destination tracker and JALR rs1 stall control
module jalr_dest_tracker #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_hold,
    input  logic              ex_flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwren,
    input  logic              id_memrd,
    input  logic              id_is_jalr,
    input  logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] EXMEM_Rd,
    output logic              EXMEM_RegWrEn,
    output logic [REG_AW-1:0] MEMWB_Rd,
    output logic              MEMWB_RegWrEn,
    output logic              jalr_stall,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wren;
        logic              memrd;
    } stage_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam stage_t BUBBLE = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           ex_q;
    stage_t           mem_q;
    stage_t           wb_q;
    state_t           state_q;
    state_t           state_d;
    logic             hazard_en;
    logic             need1;
    logic             need2;
    logic             stall;
    logic [CNT_W-1:0] cnt_q;

    // JALR rs1 dependence on an in-flight producer; x0 never forwards
    always_comb begin
        hazard_en = id_valid & id_is_jalr & (id_rs1 != '0);
        need2     = hazard_en & ex_q.valid & ex_q.wren & ex_q.memrd & (ex_q.rd == id_rs1);
        need1     = hazard_en &
                    ((ex_q.valid & ex_q.wren & ~ex_q.memrd & (ex_q.rd == id_rs1)) |
                     (mem_q.valid & mem_q.wren & mem_q.memrd & (mem_q.rd == id_rs1)));
    end

    // Stall FSM: a load in EX needs a second stall cycle after the first; flush cancels it
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = need2 | need1;
                if (need2) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (ex_flush) begin
            state_d = IDLE;
        end
    end

    // FSM state register, frozen by pipe_hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (!pipe_hold) begin
            state_q <= state_d;
        end
    end

    // Shadow pipeline advance; stalled or flushed ID slot enters EX as a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else if (!pipe_hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (stall || ex_flush) begin
                ex_q <= BUBBLE;
            end else begin
                ex_q <= '{valid: id_valid, rd: id_rd, wren: id_regwren, memrd: id_memrd};
            end
        end
    end

    // Saturating stall-cycle counter for performance monitoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!pipe_hold && stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign EXMEM_Rd      = mem_q.rd;
    assign EXMEM_RegWrEn = mem_q.valid & mem_q.wren & ~mem_q.memrd;
    assign MEMWB_Rd      = wb_q.rd;
    assign MEMWB_RegWrEn = wb_q.valid & wb_q.wren;
    assign jalr_stall    = stall;
    assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_jalr_dest_tracker.sv
// tb/tb_jalr_dest_tracker.sv - randomized and directed self-checking bench for jalr_dest_tracker
module tb_jalr_dest_tracker;

    localparam int AW      = 5;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_hold = 1'b0;
    logic          ex_flush = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwren = 1'b0;
    logic          id_memrd = 1'b0;
    logic          id_is_jalr = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] EXMEM_Rd;
    logic          EXMEM_RegWrEn;
    logic [AW-1:0] MEMWB_Rd;
    logic          MEMWB_RegWrEn;
    logic          jalr_stall;
    logic [CW-1:0] stall_cycles;

    jalr_dest_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .ex_flush(ex_flush),
        .id_valid(id_valid), .id_rd(id_rd), .id_regwren(id_regwren), .id_memrd(id_memrd),
        .id_is_jalr(id_is_jalr), .id_rs1(id_rs1),
        .EXMEM_Rd(EXMEM_Rd), .EXMEM_RegWrEn(EXMEM_RegWrEn),
        .MEMWB_Rd(MEMWB_Rd), .MEMWB_RegWrEn(MEMWB_RegWrEn),
        .jalr_stall(jalr_stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit w;
        bit m;
    } ent_t;

    // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB
    ent_t mp[3];
    int   owed;
    int   mcnt;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic bit m_haz();
        return id_valid && id_is_jalr && (id_rs1 != 0);
    endfunction

    function automatic bit m_load_in_ex();
        return m_haz() && mp[0].v && mp[0].w && mp[0].m && (mp[0].rd == int'(id_rs1));
    endfunction

    function automatic bit m_stall();
        bit alu_ex;
        bit load_mem;
        alu_ex   = mp[0].v && mp[0].w && !mp[0].m && (mp[0].rd == int'(id_rs1));
        load_mem = mp[1].v && mp[1].w && mp[1].m && (mp[1].rd == int'(id_rs1));
        return (owed > 0) || m_load_in_ex() || (m_haz() && (alu_ex || load_mem));
    endfunction

    // Reference model update on each clock edge
    always @(posedge clk or posedge rst) begin
        bit s;
        bit l2;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mp[i].v = 0; mp[i].rd = 0; mp[i].w = 0; mp[i].m = 0;
            end
            owed = 0;
            mcnt = 0;
        end else if (!pipe_hold) begin
            s  = m_stall();
            l2 = m_load_in_ex();
            if (s && mcnt < CNT_MAX) mcnt = mcnt + 1;
            owed  = (ex_flush || owed > 0) ? 0 : (l2 ? 1 : 0);
            mp[2] = mp[1];
            mp[1] = mp[0];
            if (s || ex_flush) begin
                mp[0].v = 0; mp[0].rd = 0; mp[0].w = 0; mp[0].m = 0;
            end else begin
                mp[0].v = id_valid; mp[0].rd = int'(id_rd); mp[0].w = id_regwren; mp[0].m = id_memrd;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("jalr_stall", 32'(jalr_stall), 32'(m_stall()));
        chk("EXMEM_Rd", 32'(EXMEM_Rd), 32'(mp[1].rd));
        chk("EXMEM_RegWrEn", 32'(EXMEM_RegWrEn), 32'(mp[1].v && mp[1].w && !mp[1].m));
        chk("MEMWB_Rd", 32'(MEMWB_Rd), 32'(mp[2].rd));
        chk("MEMWB_RegWrEn", 32'(MEMWB_RegWrEn), 32'(mp[2].v && mp[2].w));
        chk("stall_cycles", 32'(stall_cycles), 32'(mcnt));
    endtask

    task automatic cyc(input bit v, input int rd, input bit w, input bit m,
                       input bit j, input int rs1, input bit fl, input bit hd);
        @(negedge clk);
        id_valid = v; id_rd = AW'(rd); id_regwren = w; id_memrd = m;
        id_is_jalr = j; id_rs1 = AW'(rs1); ex_flush = fl; pipe_hold = hd;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 0; id_is_jalr = 0; ex_flush = 0; pipe_hold = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        compare_all();
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);

        // Reset asserted mid-stall drops everything immediately
        cyc(1, 7, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("lu_first_stall", 32'(jalr_stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(jalr_stall), 32'd0);
        chk("async_rst_exmem", 32'({EXMEM_Rd, EXMEM_RegWrEn}), 32'd0);
        chk("async_rst_memwb", 32'({MEMWB_Rd, MEMWB_RegWrEn}), 32'd0);
        chk("async_rst_cnt", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU-use: one stall cycle, then forwarding from MEM
        do_reset();
        cyc(1, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 5, 0, 0);
        chk("alu_stall", 32'(jalr_stall), 32'd1);
        cyc(1, 1, 1, 0, 1, 5, 0, 0);
        chk("alu_release", 32'(jalr_stall), 32'd0);
        chk("alu_exmem", 32'({EXMEM_Rd, EXMEM_RegWrEn}), 32'({5'd5, 1'b1}));
        chk("alu_cnt", 32'(stall_cycles), 32'd1);

        // Load-use: two stall cycles, then forwarding from WB
        do_reset();
        cyc(1, 7, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("lu_stall1", 32'(jalr_stall), 32'd1);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("lu_stall2", 32'(jalr_stall), 32'd1);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("lu_release", 32'(jalr_stall), 32'd0);
        chk("lu_memwb", 32'({MEMWB_Rd, MEMWB_RegWrEn}), 32'({5'd7, 1'b1}));
        chk("lu_exmem_en", 32'(EXMEM_RegWrEn), 32'd0);
        chk("lu_cnt", 32'(stall_cycles), 32'd2);

        // x0 and unrelated registers never stall
        do_reset();
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0, 0);
        chk("x0_nostall", 32'(jalr_stall), 32'd0);
        cyc(1, 3, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 4, 0, 0);
        chk("nodep_nostall", 32'(jalr_stall), 32'd0);

        // Flush during the first stall cycle cancels the second one
        do_reset();
        cyc(1, 7, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 7, 1, 0);
        chk("fl_stall1", 32'(jalr_stall), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_no_stall2", 32'(jalr_stall), 32'd0);
        chk("fl_cnt", 32'(stall_cycles), 32'd1);

        // Hold freezes a load-use stall for three cycles
        do_reset();
        cyc(1, 7, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 0, 1, 7, 0, 1);
            chk("hold_stall", 32'(jalr_stall), 32'd1);
            chk("hold_cnt", 32'(stall_cycles), 32'd0);
            chk("hold_exmem", 32'({EXMEM_Rd, EXMEM_RegWrEn}), 32'd0);
        end
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("hold_rel_stall1", 32'(jalr_stall), 32'd1);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("hold_rel_stall2", 32'(jalr_stall), 32'd1);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        chk("hold_done", 32'(jalr_stall), 32'd0);
        chk("hold_memwb", 32'({MEMWB_Rd, MEMWB_RegWrEn}), 32'({5'd7, 1'b1}));
        chk("hold_cnt_end", 32'(stall_cycles), 32'd2);

        // Randomized traffic over a small register set to provoke dependences
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, $urandom % 4, ($urandom % 4) != 0, ($urandom % 3) == 0,
                $urandom % 2, $urandom % 4, ($urandom % 10) == 0, ($urandom % 8) == 0);
        end

        // Drive the counter into saturation
        for (int i = 0; i < 70; i++) begin
            cyc(1, 5, 1, 0, 0, 0, 0, 0);
            cyc(1, 1, 1, 0, 1, 5, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
        end
        chk("sat_cnt", 32'(stall_cycles), 32'(CNT_MAX));
        cyc(1, 7, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        cyc(1, 1, 1, 0, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_hold_cnt", 32'(stall_cycles), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jalr_dest_tracker.md
Name: jalr_dest_tracker

Overview:
- Producer side of the JALR forwarding interface.
- Tracks destination registers of in-flight instructions through shadow EX, MEM and WB stages.
- Publishes EXMEM_Rd/EXMEM_RegWrEn and MEMWB_Rd/MEMWB_RegWrEn to the ID-stage JALR forwarding unit.
- Stalls IF/ID when a JALR rs1 cannot yet be satisfied by forwarding (ALU result still in EX, or load not yet in WB), and counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_hold  in  1  global pipeline freeze (e.g. memory wait); all state holds.
- ex_flush  in  1  kill the instruction entering EX; it becomes a bubble.
- id_valid  in  1  valid instruction in ID.
- id_rd  in  REG_AW  ID destination register.
- id_regwren  in  1  ID instruction writes rd.
- id_memrd  in  1  ID instruction is a load.
- id_is_jalr  in  1  ID instruction is JALR.
- id_rs1  in  REG_AW  ID rs1.
- EXMEM_Rd  out  REG_AW  rd of the MEM-stage instruction.
- EXMEM_RegWrEn  out  1  MEM-stage instruction is valid, writes rd, and is not a load.
- MEMWB_Rd  out  REG_AW  rd of the WB-stage instruction.
- MEMWB_RegWrEn  out  1  WB-stage instruction is valid and writes rd.
- jalr_stall  out  1  hold PC and IF/ID; inject a bubble into EX.
- stall_cycles  out  CNT_W  saturating count of cycles with jalr_stall=1.

Behaviour:
- Shadow stages: ex, mem, wb. Each holds {valid, rd, wren, memrd}.
- Reset (async): all shadow valid=0, rd=0, wren=0, memrd=0; state=IDLE; stall_cycles=0.
  - Outputs during and after reset: EXMEM_Rd=0, EXMEM_RegWrEn=0, MEMWB_Rd=0, MEMWB_RegWrEn=0, jalr_stall=0.
- Advance: on each clk with pipe_hold=0, wb<=mem and mem<=ex.
  - ex <= {id_valid, id_rd, id_regwren, id_memrd} when jalr_stall=0 and ex_flush=0.
  - Otherwise ex <= bubble (valid=0).
- pipe_hold=1: no shadow, FSM or counter update. jalr_stall output is still driven from current state.
- EXMEM_* are driven from mem; MEMWB_* are driven from wb. All outputs are registered values; no combinational input-to-output path except jalr_stall.
- Hazard detect is combinational and applies only when id_valid, id_is_jalr and id_rs1!=0:
  - need2: ex.valid & ex.wren & ex.memrd & ex.rd==id_rs1.
  - need1: (ex.valid & ex.wren & ~ex.memrd & ex.rd==id_rs1) | (mem.valid & mem.wren & mem.memrd & mem.rd==id_rs1).
  - rd=0 producers never cause a hazard.
- FSM:
  - IDLE: jalr_stall = need2|need1. On need2 (and pipe_hold=0) go to STALL; otherwise stay in IDLE.
  - STALL: jalr_stall=1 unconditionally. Next un-held edge returns to IDLE.
  - Stall totals: load-use = 2 cycles, ALU-use = 1 cycle, load in MEM = 1 cycle.
- ex_flush=1: FSM goes to IDLE on the next un-held edge regardless of state. A flush also clears a pending STALL.
- Simultaneous ex_flush and jalr_stall: ex gets a bubble, exactly once.
- stall_cycles: +1 on each un-held edge with jalr_stall=1. Saturates at all-ones; no wrap.
- Reset asserted mid-stall: jalr_stall drops immediately (async). All stages clear.

Test Plan:
- Reset: assert rst with stall active -> jalr_stall=0, all Rd/RegWrEn=0, stall_cycles=0 in the same cycle.
- ALU-use: ADD x5, then JALR rs1=x5 -> jalr_stall=1 for 1 cycle.
  - Next cycle: EXMEM_Rd=5, EXMEM_RegWrEn=1, jalr_stall=0.
  - stall_cycles=1.
- Load-use: LW x7, then JALR rs1=x7 -> jalr_stall=1 for 2 cycles (state IDLE->STALL->IDLE).
  - Then MEMWB_Rd=7, MEMWB_RegWrEn=1, EXMEM_RegWrEn=0.
  - stall_cycles=2.
- x0 and no-dependence: LW x0 then JALR rs1=x0 -> jalr_stall=0. ADD x3 then JALR rs1=x4 -> jalr_stall=0.
- Flush during STALL: LW x7, JALR rs1=x7, ex_flush=1 in the first stall cycle -> state IDLE next edge; no second stall cycle.
- Hold and saturation:
  - pipe_hold=1 for 3 cycles during a load-use stall -> outputs and stall_cycles frozen; stall completes after release.
  - Preload counter to all-ones -> further stalls leave it at all-ones.
